// File: rtl/fifo_pkg.sv
// Shared definitions for the fifos library: default sizes and pointer/count width helpers.
package fifo_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/pipeline_fifo_ehr2.sv
// Two-port ephemeral history register: port 1 observes the value after the port 0 write.
module pipeline_fifo_ehr2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wv0,
  input  logic [W-1:0] wd0,
  input  logic         wv1,
  input  logic [W-1:0] wd1,
  output logic [W-1:0] rd0,
  output logic [W-1:0] rd1
);

  logic [W-1:0] val_r;
  logic [W-1:0] nxt_s;

  assign rd0 = val_r;

  // port 1 read sees the port 0 write of the same cycle
  always_comb begin
    if (wv0) begin
      rd1 = wd0;
    end else begin
      rd1 = val_r;
    end
  end

  // port 1 write wins over port 0 write
  always_comb begin
    if (wv1) begin
      nxt_s = wd1;
    end else begin
      nxt_s = rd1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r <= {W{1'b0}};
    end else begin
      val_r <= nxt_s;
    end
  end

endmodule

// File: rtl/pipeline_fifo.sv
// Pipeline FIFO (deq < enq < clear) built on Ehr2 pointers and count.
// Optional flush port enabled by defining PIPELINE_FIFO_CLEAR_EN.
module pipeline_fifo
  import fifo_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_valid,
  input  logic [N-1:0]  enq_data,
  output logic          enq_ready,
  output logic          deq_valid,
  output logic [N-1:0]  deq_data,
  input  logic          deq_ready,
  output logic [CW-1:0] count
`ifdef PIPELINE_FIFO_CLEAR_EN
  ,
  input  logic          clear
`endif
);

  localparam int PW = ptr_w(DEPTH);

  logic [N-1:0]  mem_r [DEPTH];

  logic [PW-1:0] head_rd0_s, head_rd1_s, head_wd0_s;
  logic [PW-1:0] tail_rd0_s, tail_rd1_s, tail_wd1_s;
  logic [CW-1:0] cnt_rd0_s, cnt_rd1_s, cnt_wd0_s, cnt_wd1_s;
  logic          tail_wv1_s, cnt_wv1_s;
  logic          deq_fire_s, enq_fire_s, clear_s;
  logic          head_unused_s;

`ifdef PIPELINE_FIFO_CLEAR_EN
  assign clear_s = clear;
`else
  assign clear_s = 1'b0;
`endif

  assign deq_valid  = (cnt_rd0_s != {CW{1'b0}});
  assign enq_ready  = (cnt_rd0_s != CW'(DEPTH)) | deq_ready;
  assign deq_fire_s = deq_valid & deq_ready;
  assign enq_fire_s = enq_valid & enq_ready;
  assign deq_data   = mem_r[head_rd0_s];
  assign count      = cnt_rd0_s;

  assign head_wd0_s    = head_rd0_s + PW'(1);
  assign cnt_wd0_s     = cnt_rd0_s - CW'(1);
  assign tail_wv1_s    = enq_fire_s | clear_s;
  assign cnt_wv1_s     = enq_fire_s | clear_s;
  assign head_unused_s = ^head_rd1_s;

  // enq-port updates; clear forces pointers and count to zero
  always_comb begin
    if (clear_s) begin
      tail_wd1_s = {PW{1'b0}};
      cnt_wd1_s  = {CW{1'b0}};
    end else begin
      tail_wd1_s = tail_rd1_s + PW'(1);
      cnt_wd1_s  = cnt_rd1_s + CW'(1);
    end
  end

  pipeline_fifo_ehr2 #(.W(PW)) u_head (
    .clk (clk),
    .rst_n (rst_n),
    .wv0 (deq_fire_s),
    .wd0 (head_wd0_s),
    .wv1 (clear_s),
    .wd1 ({PW{1'b0}}),
    .rd0 (head_rd0_s),
    .rd1 (head_rd1_s)
  );

  pipeline_fifo_ehr2 #(.W(PW)) u_tail (
    .clk (clk),
    .rst_n (rst_n),
    .wv0 (1'b0),
    .wd0 (tail_rd0_s),
    .wv1 (tail_wv1_s),
    .wd1 (tail_wd1_s),
    .rd0 (tail_rd0_s),
    .rd1 (tail_rd1_s)
  );

  pipeline_fifo_ehr2 #(.W(CW)) u_count (
    .clk (clk),
    .rst_n (rst_n),
    .wv0 (deq_fire_s),
    .wd0 (cnt_wd0_s),
    .wv1 (cnt_wv1_s),
    .wd1 (cnt_wd1_s),
    .rd0 (cnt_rd0_s),
    .rd1 (cnt_rd1_s)
  );

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (enq_fire_s && !clear_s) begin
      mem_r[tail_rd1_s] <= enq_data;
    end else begin
      mem_r[tail_rd1_s] <= mem_r[tail_rd1_s];
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Scoreboard bench for pipeline_fifo (DEPTH=4, N=32); clear test runs with PIPELINE_FIFO_CLEAR_EN.
module tb_pipeline_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_data = 32'h0;
  logic        enq_ready;
  logic        deq_valid;
  logic [31:0] deq_data;
  logic        deq_ready = 1'b0;
  logic [2:0]  count;
  logic        clear = 1'b0;

  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipeline_fifo dut (
    .clk (clk),
    .rst_n (rst_n),
    .enq_valid (enq_valid),
    .enq_data (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data (deq_data),
    .deq_ready (deq_ready),
    .count (count)
`ifdef PIPELINE_FIFO_CLEAR_EN
    ,
    .clear (clear)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare head data against the scoreboard whenever a deq fires
  always @(negedge clk) begin
    if (rst_n && deq_valid && deq_ready && !clear) begin
      if (sb.size() == 0) begin
        chk("deq_unexpected", deq_data, 32'hFFFF_FFFF);
      end else begin
        chk("deq_data", deq_data, sb.pop_front());
      end
    end
  end

  // one cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic step(input logic ev, input logic [31:0] ed, input logic dr, input logic clr);
    logic exp_rdy;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    clear     = clr;
    #1;
    exp_rdy = (m_cnt != 4) || dr;
    chk("enq_ready", {31'h0, enq_ready}, {31'h0, exp_rdy});
    chk("deq_valid", {31'h0, deq_valid}, {31'h0, (m_cnt != 0)});
    chk("count", {29'h0, count}, m_cnt);
    if (clr) begin
      m_cnt = 0;
    end else begin
      if (ev && exp_rdy) sb.push_back(ed);
      m_cnt = m_cnt - ((dr && m_cnt != 0) ? 1 : 0) + ((ev && exp_rdy) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    if (clr) sb.delete();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 4 cycles
    repeat (4) @(posedge clk);
    #1;
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_deq_valid", {31'h0, deq_valid}, 32'd0);
    chk("rst_enq_ready", {31'h0, enq_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // mid-stream asynchronous reset after 2 enqs
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    chk("pre_arst_count", {29'h0, count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {29'h0, count}, 32'd0);
    chk("arst_deq_valid", {31'h0, deq_valid}, 32'd0);
    chk("arst_enq_ready", {31'h0, enq_ready}, 32'd1);
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill then drain
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b0, 1'b0);   // full, not accepted
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);    // empty deq guard

    // full pass-through
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + i, 1'b0, 1'b0);
    step(1'b1, 32'hC0, 1'b1, 1'b0);
    chk("pass_count", {29'h0, count}, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // wrap-around at constant occupancy 1
    step(1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h101 + i, 1'b1, 1'b0);
    chk("wrap_count", {29'h0, count}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // enq into empty with deq_ready high
    step(1'b1, 32'h55, 1'b1, 1'b0);
    chk("empty_enq_data", deq_data, 32'h55);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPELINE_FIFO_CLEAR_EN
    for (int i = 0; i < 3; i++) step(1'b1, 32'hD0 + i, 1'b0, 1'b0);
    step(1'b1, 32'hDD, 1'b1, 1'b1);
    chk("clr_count", {29'h0, count}, 32'd0);
    chk("clr_deq_valid", {31'h0, deq_valid}, 32'd0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("clr_enq_data", deq_data, 32'h77);
    step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
